hazard_forward_unit: RTL and testbench

// - Control end of the EX-stage operand forwarding muxes: generates the 2-bit select codes
//   (forward_a/forward_b) and the load-use stall for the 5-stage RV32I pipeline.
// - Keeps its own shadow pipeline of register-use metadata (EX, MEM, WB), fed from the ID stage.
// - Sits beside the ID/EX register; its selects drive both operand muxes; stall drives PC/IF-ID enable.

---
 rtl/hazard_forward_unit_pkg.sv | 15 +
 rtl/hazard_forward_unit_fwd_select.sv | 38 +++
 rtl/hazard_forward_unit.sv | 116 +++++++++++
 tb/tb_hazard_forward_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the EX-stage forwarding control. The select encoding here is the
// same one the operand muxes decode, so both sides must import this package.
package hazard_forward_unit_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam logic [DEF_REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority compare of one EX source operand against the MEM and WB producers.
// MEM is the younger producer, so it wins when both stages hold the same destination.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write to it is never a forwarding source.
  assign mem_hit = src_used && mem_valid && mem_regwrite &&
                   (mem_rd != REG_ADDR_W'(REG_X0)) && (mem_rd == src_idx);
  assign wb_hit  = src_used && wb_valid && wb_regwrite &&
                   (wb_rd != REG_ADDR_W'(REG_X0)) && (wb_rd == src_idx);

  always_comb begin
    // NOTE: default assignment first so every path drives sel and no latch is inferred.
    sel = FWD_NONE;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall control for the 5-stage RV32I pipeline.
// Tracks register-use metadata of the instructions in EX, MEM and WB in a shadow pipeline.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } late_stage_t;

  ex_stage_t   ex_q;
  ex_stage_t   ex_d;
  late_stage_t mem_q;
  late_stage_t wb_q;

  logic ex_load_pending;
  logic rs1_hit;
  logic rs2_hit;

  // A load in EX cannot supply data until WB, so a dependent in ID must wait one cycle.
  assign ex_load_pending = ex_q.valid && ex_q.memread && ex_q.regwrite &&
                           (ex_q.rd != REG_ADDR_W'(REG_X0));
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign stall   = id_valid && !flush && ex_load_pending && (rs1_hit || rs2_hit);

  always_comb begin
    ex_d = '0;
    if (id_valid && !flush && !stall) begin
      ex_d = '{valid:    1'b1,
               rs1:      id_rs1,
               rs2:      id_rs2,
               use1:     id_use_rs1,
               use2:     id_use_rs2,
               rd:       id_rd,
               regwrite: id_regwrite,
               memread:  id_memread};
    end
  end

  // The shadow stages advance every cycle; a stall only turns the EX entry into a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
      wb_q  <= mem_q;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

  // Selects depend only on registered state, so they never glitch with the ID inputs.
  hazard_forward_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_used     (ex_q.valid && ex_q.use1),
    .src_idx      (ex_q.rs1),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (forward_a)
  );

  hazard_forward_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_used     (ex_q.valid && ex_q.use2),
    .src_idx      (ex_q.rs2),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (forward_b)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a reference pipeline model predicts each cycle's
// outputs, directed checks pin the headline scenarios; a 2-bit-counter copy covers saturation.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;

  logic        stall;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [15:0] stall_count;
  logic        sat_stall;
  logic [1:0]  sat_forward_a;
  logic [1:0]  sat_forward_b;
  logic [1:0]  sat_stall_count;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .forward_a(forward_a), .forward_b(forward_b), .stall_count(stall_count)
  );

  hazard_forward_unit #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(sat_stall), .forward_a(sat_forward_a), .forward_b(sat_forward_b),
    .stall_count(sat_stall_count)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       regw;
    logic       memr;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
    logic        ex_valid;
  } exp_t;

  exp_t sb[$];

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  instr_t      pipe [3];
  int unsigned m_cnt;
  int unsigned m_cnt_sat;

  int n_checks = 0;
  int n_pass   = 0;
  bit checks_on = 1'b0;
  int last_cycles;

  logic        obs_stall;
  logic [1:0]  obs_fa;
  logic [1:0]  obs_fb;
  logic [15:0] obs_cnt;
  logic [1:0]  obs_cnt_sat;
  logic        obs_ex_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{valid: 1'b1, rs1: rs1, rs2: rs2, use1: 1'b1, use2: 1'b1, rd: rd, regw: 1'b1, memr: 1'b0};
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] base);
    return '{valid: 1'b1, rs1: base, rs2: 5'd0, use1: 1'b1, use2: 1'b0, rd: rd, regw: 1'b1, memr: 1'b1};
  endfunction

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t rand_instr();
    return instr_t'($urandom);
  endfunction

  // Youngest in-flight writer of src (MEM before WB) decides the select.
  function automatic logic [1:0] model_sel(input logic used, input logic [4:0] src);
    for (int age = 1; age <= 2; age++) begin
      if (used && pipe[age].valid && pipe[age].regw && pipe[age].rd != 5'd0 && pipe[age].rd == src)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    e = sb.pop_front();
    obs_stall    = stall;
    obs_fa       = forward_a;
    obs_fb       = forward_b;
    obs_cnt      = stall_count;
    obs_cnt_sat  = sat_stall_count;
    obs_ex_valid = dut.ex_q.valid;
    if (checks_on) begin
      check("stall", stall, e.stall);
      check("forward_a", forward_a, e.fa);
      check("forward_b", forward_b, e.fb);
      check("stall_count", stall_count, e.cnt);
      check("sat_stall", sat_stall, e.stall);
      check("sat_forward_a", sat_forward_a, e.fa);
      check("sat_forward_b", sat_forward_b, e.fb);
      check("sat_stall_count", sat_stall_count, e.cnt_sat);
      check("ex_valid", dut.ex_q.valid, e.ex_valid);
    end
  endtask

  // One clock: drive ID at negedge, predict, sample 1 time unit later, advance model at posedge.
  task automatic cycle(input instr_t id, input logic f, input logic rst, output logic stalled);
    exp_t e;
    logic hit;
    @(negedge clk);
    rst_n       = rst;
    id_valid    = id.valid;
    id_rs1      = id.rs1;
    id_rs2      = id.rs2;
    id_use_rs1  = id.use1;
    id_use_rs2  = id.use2;
    id_rd       = id.rd;
    id_regwrite = id.regw;
    id_memread  = id.memr;
    flush       = f;
    hit = (id.use1 && id.rs1 == pipe[0].rd) || (id.use2 && id.rs2 == pipe[0].rd);
    e.stall    = id.valid && !f && pipe[0].valid && pipe[0].memr && pipe[0].regw &&
                 pipe[0].rd != 5'd0 && hit;
    e.fa       = model_sel(pipe[0].valid && pipe[0].use1, pipe[0].rs1);
    e.fb       = model_sel(pipe[0].valid && pipe[0].use2, pipe[0].rs2);
    e.cnt      = m_cnt[15:0];
    e.cnt_sat  = m_cnt_sat[1:0];
    e.ex_valid = pipe[0].valid;
    sb.push_back(e);
    stalled = e.stall;
    #1;
    compare_outputs();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_cnt = 0;
      m_cnt_sat = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (f || e.stall || !id.valid) ? nop() : id;
      if (e.stall) begin
        if (m_cnt < 32'd65535) m_cnt++;
        if (m_cnt_sat < 32'd3) m_cnt_sat++;
      end
    end
  endtask

  // Presents an instruction in ID, holding it there while the model predicts a stall.
  task automatic issue(input instr_t id, input logic f);
    logic st;
    last_cycles = 0;
    do begin
      cycle(id, f, 1'b1, st);
      last_cycles++;
    end while (st && last_cycles < 4);
    if (st) check("stall_bound", st, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) issue(nop(), 1'b0);
  endtask

  logic st_dummy;

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt = 0;
    m_cnt_sat = 0;

    // Reset held 3 cycles with random ID traffic; the pre-reset cycle is unknown state.
    cycle(rand_instr(), 1'b0, 1'b0, st_dummy);
    checks_on = 1'b1;
    cycle(rand_instr(), 1'b0, 1'b0, st_dummy);
    cycle(rand_instr(), 1'b0, 1'b0, st_dummy);
    check("reset_stall", obs_stall, 1'b0);
    check("reset_fa", obs_fa, 2'b00);
    check("reset_cnt", obs_cnt, 16'd0);
    cycle(rand_instr(), $urandom_range(0, 1) == 1, 1'b1, st_dummy);
    check("post_reset_stall", obs_stall, 1'b0);
    check("post_reset_fb", obs_fb, 2'b00);
    check("post_reset_cnt", obs_cnt, 16'd0);
    drain();

    // EX->EX: add x5 ; sub x6,x5,x7
    issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
    issue(alu(5'd6, 5'd5, 5'd7), 1'b0);
    check("exex_nostall", last_cycles, 1);
    issue(nop(), 1'b0);
    check("exex_fa", obs_fa, 2'b10);
    check("exex_fb", obs_fb, 2'b00);
    drain();

    // MEM->EX via WB stage: add x5 ; nop ; sub x6,x5,x5
    issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
    issue(nop(), 1'b0);
    issue(alu(5'd6, 5'd5, 5'd5), 1'b0);
    issue(nop(), 1'b0);
    check("wb_fa", obs_fa, 2'b01);
    check("wb_fb", obs_fb, 2'b01);
    drain();

    // Priority: add x5 ; add x5 ; sub x6,x5,x5 -> MEM wins
    issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
    issue(alu(5'd5, 5'd3, 5'd4), 1'b0);
    issue(alu(5'd6, 5'd5, 5'd5), 1'b0);
    issue(nop(), 1'b0);
    check("prio_fa", obs_fa, 2'b10);
    check("prio_fb", obs_fb, 2'b10);
    drain();

    // Load-use: lw x8 ; add x9,x8,x1 -> one stall cycle, then WB forward after the bubble
    issue(lw(5'd8, 5'd2), 1'b0);
    issue(alu(5'd9, 5'd8, 5'd1), 1'b0);
    check("lu_cycles", last_cycles, 2);
    issue(nop(), 1'b0);
    check("lu_fa", obs_fa, 2'b01);
    check("lu_fb", obs_fb, 2'b00);
    check("lu_cnt", obs_cnt, 16'd1);
    drain();

    // Load followed by an instruction that does not read rs1 (rs1 field still x8)
    issue(lw(5'd8, 5'd2), 1'b0);
    issue('{valid: 1'b1, rs1: 5'd8, rs2: 5'd1, use1: 1'b0, use2: 1'b1,
            rd: 5'd9, regw: 1'b1, memr: 1'b0}, 1'b0);
    check("nouse_cycles", last_cycles, 1);
    drain();

    // x0 is never forwarded, and a load to x0 never stalls
    issue(alu(5'd0, 5'd1, 5'd2), 1'b0);
    issue(lw(5'd0, 5'd3), 1'b0);
    issue(alu(5'd3, 5'd0, 5'd0), 1'b0);
    check("x0_nostall", last_cycles, 1);
    issue(nop(), 1'b0);
    check("x0_fa", obs_fa, 2'b00);
    check("x0_fb", obs_fb, 2'b00);
    drain();

    // Flush beats stall: dependent squashed, never reaches EX
    issue(lw(5'd8, 5'd2), 1'b0);
    issue(alu(5'd9, 5'd8, 5'd1), 1'b1);
    check("flush_stall", obs_stall, 1'b0);
    issue(nop(), 1'b0);
    check("flush_ex_valid", obs_ex_valid, 1'b0);
    check("flush_cnt", obs_cnt, 16'd1);
    drain();

    // Saturation: five more load-use pairs
    for (int i = 0; i < 5; i++) begin
      issue(lw(5'd8, 5'd2), 1'b0);
      issue(alu(5'd9, 5'd1, 5'd8), 1'b0);
    end
    drain();
    check("sat_cnt", obs_cnt_sat, 2'd3);
    check("full_cnt", obs_cnt, 16'd6);
    issue(lw(5'd10, 5'd2), 1'b0);
    issue(alu(5'd11, 5'd10, 5'd10), 1'b0);
    drain();
    check("sat_hold", obs_cnt_sat, 2'd3);

    // Reset mid-stream discards in-flight writers and clears the counters
    issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
    issue(alu(5'd6, 5'd1, 5'd2), 1'b0);
    issue(lw(5'd8, 5'd2), 1'b0);
    cycle(alu(5'd9, 5'd8, 5'd5), 1'b0, 1'b0, st_dummy);
    issue(alu(5'd7, 5'd5, 5'd6), 1'b0);
    check("midrst_cnt", obs_cnt, 16'd0);
    check("midrst_sat_cnt", obs_cnt_sat, 2'd0);
    check("midrst_fa", obs_fa, 2'b00);
    issue(nop(), 1'b0);
    check("midrst_ex_fa", obs_fa, 2'b00);
    check("midrst_ex_fb", obs_fb, 2'b00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
